// File: rtl/id_inst_queue.sv
// IF->ID instruction buffer: DEPTH-entry FIFO with valid/allow_in handshakes on both sides.
// A redirect (flush) discards all queued wrong-path instructions; storage itself is left untouched.
module id_inst_queue #(
    parameter int BUS_WD          = 64,
    parameter int DEPTH           = 4,
    parameter int ALLOW_FULL_PASS = 0,
    localparam int CNT_W          = $clog2(DEPTH + 1),
    localparam int PTR_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IF_to_ID_valid,
    input  logic [BUS_WD-1:0] IF_to_ID_bus,
    output logic              Q_allow_in,
    output logic              Q_to_ID_valid,
    output logic [BUS_WD-1:0] Q_to_ID_bus,
    input  logic              ID_allow_in,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [BUS_WD-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              full_w;
    logic              empty_w;
    logic              push;
    logic              pop;
    logic [BUS_WD-1:0] head;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = p + 1'b1;
        end
    endfunction

    assign full_w  = (cnt == CNT_W'(DEPTH));
    assign empty_w = (cnt == '0);

    assign pop  = ~empty_w & ID_allow_in;
    assign push = IF_to_ID_valid & Q_allow_in;

    generate
        if (ALLOW_FULL_PASS != 0) begin : g_full_pass
            assign Q_allow_in = ~full_w | pop;
        end else begin : g_no_full_pass
            assign Q_allow_in = ~full_w;
        end
    endgenerate

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PTR_W'(i)) begin
                head = mem[i];
            end
        end
    end

    assign Q_to_ID_valid = ~empty_w;
    assign Q_to_ID_bus   = head;
    assign count         = cnt;
    assign full          = full_w;
    assign empty         = empty_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A push coinciding with a flush is dropped; flush does not clear storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == PTR_W'(i)) begin
                    mem[i] <= IF_to_ID_bus;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue: DEPTH=4 (with and without full pass), DEPTH=1 pass-through, DEPTH=3 wrap.
module tb_id_inst_queue;

    logic clk;
    logic reset;

    logic        v4, a4, f4;
    logic [63:0] b4;
    logic        d4_allow, d4_valid, d4_full, d4_empty;
    logic [63:0] d4_bus;
    logic [2:0]  d4_count;
    logic        p4_allow, p4_valid, p4_full, p4_empty;
    logic [63:0] p4_bus;
    logic [2:0]  p4_count;

    logic        v3, a3, f3;
    logic [63:0] b3;
    logic        d3_allow, d3_valid, d3_full, d3_empty;
    logic [63:0] d3_bus;
    logic [1:0]  d3_count;

    logic        v1, a1, f1;
    logic [63:0] b1;
    logic        d1_allow, d1_valid, d1_full, d1_empty;
    logic [63:0] d1_bus;
    logic [0:0]  d1_count;

    int n_cmp;
    int n_err;

    logic [63:0] e [0:4];
    logic [63:0] s [0:7];
    logic [63:0] t [0:9];
    logic [19:0] pat;
    logic [63:0] mq [$];
    int          sent, got;
    logic        push_m, pop_m;

    id_inst_queue #(.BUS_WD(64), .DEPTH(4), .ALLOW_FULL_PASS(0)) u_d4 (
        .clk(clk), .reset(reset), .IF_to_ID_valid(v4), .IF_to_ID_bus(b4),
        .Q_allow_in(d4_allow), .Q_to_ID_valid(d4_valid), .Q_to_ID_bus(d4_bus),
        .ID_allow_in(a4), .flush(f4), .count(d4_count), .full(d4_full), .empty(d4_empty)
    );

    id_inst_queue #(.BUS_WD(64), .DEPTH(4), .ALLOW_FULL_PASS(1)) u_p4 (
        .clk(clk), .reset(reset), .IF_to_ID_valid(v4), .IF_to_ID_bus(b4),
        .Q_allow_in(p4_allow), .Q_to_ID_valid(p4_valid), .Q_to_ID_bus(p4_bus),
        .ID_allow_in(a4), .flush(f4), .count(p4_count), .full(p4_full), .empty(p4_empty)
    );

    id_inst_queue #(.BUS_WD(64), .DEPTH(3), .ALLOW_FULL_PASS(0)) u_d3 (
        .clk(clk), .reset(reset), .IF_to_ID_valid(v3), .IF_to_ID_bus(b3),
        .Q_allow_in(d3_allow), .Q_to_ID_valid(d3_valid), .Q_to_ID_bus(d3_bus),
        .ID_allow_in(a3), .flush(f3), .count(d3_count), .full(d3_full), .empty(d3_empty)
    );

    id_inst_queue #(.BUS_WD(64), .DEPTH(1), .ALLOW_FULL_PASS(1)) u_d1 (
        .clk(clk), .reset(reset), .IF_to_ID_valid(v1), .IF_to_ID_bus(b1),
        .Q_allow_in(d1_allow), .Q_to_ID_valid(d1_valid), .Q_to_ID_bus(d1_bus),
        .ID_allow_in(a1), .flush(f1), .count(d1_count), .full(d1_full), .empty(d1_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        e[0] = 64'h10000004_24080001;
        e[1] = 64'h10000008_24080002;
        e[2] = 64'h1000000C_24080003;
        e[3] = 64'h10000010_24080004;
        e[4] = 64'h10000014_24080005;
        for (int i = 0; i < 8; i++) s[i] = {32'h20000000 + 32'(4 * i), 32'h8C000000 + 32'(i)};
        for (int i = 0; i < 10; i++) t[i] = {32'h30000000 + 32'(4 * i), 32'h00000100 + 32'(i)};
        pat = 20'b1101_1001_0100_0110_0000;

        reset = 1'b1;
        v4 = 0; a4 = 0; f4 = 0; b4 = '0;
        v3 = 0; a3 = 0; f3 = 0; b3 = '0;
        v1 = 0; a1 = 0; f1 = 0; b1 = '0;

        // reset values
        #2;
        chk("rst_empty", 64'(d4_empty), 64'd1);
        chk("rst_full", 64'(d4_full), 64'd0);
        chk("rst_count", 64'(d4_count), 64'd0);
        chk("rst_valid", 64'(d4_valid), 64'd0);
        chk("rst_allow", 64'(d4_allow), 64'd1);
        chk("rst_bus", d4_bus, 64'd0);
        chk("rst_d3_empty", 64'(d3_empty), 64'd1);
        chk("rst_d1_allow", 64'(d1_allow), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step;
        chk("idle_empty", 64'(d4_empty), 64'd1);
        chk("idle_count", 64'(d4_count), 64'd0);
        chk("idle_allow", 64'(d4_allow), 64'd1);
        chk("idle_bus", d4_bus, 64'd0);

        // fill DEPTH=4 with ID stalled
        v4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b4 = e[k];
            step;
            chk("fill_count", 64'(d4_count), 64'(k + 1));
            chk("fill_count_p", 64'(p4_count), 64'(k + 1));
            chk("fill_head", d4_bus, e[0]);
        end
        b4 = e[4];
        #1;
        chk("full_flag", 64'(d4_full), 64'd1);
        chk("full_allow", 64'(d4_allow), 64'd0);
        chk("full_allow_p", 64'(p4_allow), 64'd0);
        step;
        chk("held_count", 64'(d4_count), 64'd4);
        chk("held_count_p", 64'(p4_count), 64'd4);

        // drain; pass variant accepts the held fifth instruction on the pop edge
        a4 = 1'b1;
        #1;
        chk("pop_allow", 64'(d4_allow), 64'd0);
        chk("pop_allow_p", 64'(p4_allow), 64'd1);
        step;
        v4 = 1'b0;
        chk("drain1_count", 64'(d4_count), 64'd3);
        chk("drain1_head", d4_bus, e[1]);
        chk("drain1_count_p", 64'(p4_count), 64'd4);
        chk("drain1_full_p", 64'(p4_full), 64'd1);
        step;
        chk("drain2_head", d4_bus, e[2]);
        chk("drain2_count_p", 64'(p4_count), 64'd3);
        step;
        chk("drain3_head", d4_bus, e[3]);
        chk("drain3_head_p", p4_bus, e[3]);
        step;
        chk("drain4_empty", 64'(d4_empty), 64'd1);
        chk("drain4_valid", 64'(d4_valid), 64'd0);
        chk("drain4_head_p", p4_bus, e[4]);
        chk("drain4_valid_p", 64'(p4_valid), 64'd1);
        step;
        chk("empty_pop_count", 64'(d4_count), 64'd0);
        chk("drain5_empty_p", 64'(p4_empty), 64'd1);
        a4 = 1'b0;

        // simultaneous push and pop at count 2
        v4 = 1'b1;
        b4 = s[0];
        step;
        b4 = s[1];
        step;
        chk("pp_pre_count", 64'(d4_count), 64'd2);
        chk("pp_pre_head", d4_bus, s[0]);
        a4 = 1'b1;
        b4 = s[2];
        step;
        v4 = 1'b0;
        chk("pp_count", 64'(d4_count), 64'd2);
        chk("pp_head", d4_bus, s[1]);
        step;
        chk("pp_next_head", d4_bus, s[2]);
        chk("pp_next_count", 64'(d4_count), 64'd1);
        step;
        chk("pp_end_empty", 64'(d4_empty), 64'd1);
        a4 = 1'b0;

        // flush at count 3 with a coincident push
        v4 = 1'b1;
        for (int k = 3; k < 6; k++) begin
            b4 = s[k];
            step;
        end
        chk("fl_pre_count", 64'(d4_count), 64'd3);
        b4 = s[6];
        f4 = 1'b1;
        step;
        f4 = 1'b0;
        v4 = 1'b0;
        chk("fl_count", 64'(d4_count), 64'd0);
        chk("fl_valid", 64'(d4_valid), 64'd0);
        chk("fl_empty_p", 64'(p4_empty), 64'd1);
        v4 = 1'b1;
        b4 = s[7];
        step;
        v4 = 1'b0;
        chk("fl_after_head", d4_bus, s[7]);
        chk("fl_after_count", 64'(d4_count), 64'd1);
        a4 = 1'b1;
        step;
        a4 = 1'b0;
        f4 = 1'b1;
        step;
        f4 = 1'b0;
        chk("fl_empty_count", 64'(d4_count), 64'd0);
        chk("fl_empty_allow", 64'(d4_allow), 64'd1);

        // DEPTH=1 with full pass behaves as the old pipeline register
        v1 = 1'b1;
        b1 = s[1];
        step;
        chk("d1_count", 64'(d1_count), 64'd1);
        chk("d1_full", 64'(d1_full), 64'd1);
        chk("d1_head", d1_bus, s[1]);
        b1 = s[2];
        #1;
        chk("d1_stall_allow", 64'(d1_allow), 64'd0);
        a1 = 1'b1;
        #1;
        chk("d1_pass_allow", 64'(d1_allow), 64'd1);
        step;
        v1 = 1'b0;
        chk("d1_pass_head", d1_bus, s[2]);
        chk("d1_pass_valid", 64'(d1_valid), 64'd1);
        step;
        a1 = 1'b0;
        chk("d1_drain_empty", 64'(d1_empty), 64'd1);

        // DEPTH=3 stream with stalls, exercising pointer wrap
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            v3 = (sent < 10);
            b3 = (sent < 10) ? t[sent] : 64'd0;
            a3 = pat[cyc % 20];
            #1;
            chk("st_count", 64'(d3_count), 64'(mq.size()));
            chk("st_full", 64'(d3_full), 64'(mq.size() == 3));
            chk("st_allow", 64'(d3_allow), 64'(mq.size() < 3));
            if (mq.size() > 0) chk("st_head", d3_bus, mq[0]);
            push_m = v3 && (mq.size() < 3);
            pop_m  = a3 && (mq.size() > 0);
            step;
            if (pop_m) begin
                void'(mq.pop_front());
                got++;
            end
            if (push_m) begin
                mq.push_back(t[sent]);
                sent++;
            end
        end
        chk("st_all_popped", 64'(got), 64'd10);
        v3 = 1'b0;
        a3 = 1'b0;

        // asynchronous reset between edges
        v3 = 1'b1;
        b3 = t[0];
        step;
        b3 = t[1];
        step;
        chk("ar_pre_count", 64'(d3_count), 64'd2);
        #3 reset = 1'b1;
        #1;
        chk("ar_empty", 64'(d3_empty), 64'd1);
        chk("ar_count", 64'(d3_count), 64'd0);
        chk("ar_valid", 64'(d3_valid), 64'd0);
        chk("ar_allow", 64'(d3_allow), 64'd1);
        chk("ar_bus", d3_bus, 64'd0);
        #2;
        reset = 1'b0;
        v3 = 1'b0;
        step;
        chk("ar_post_empty", 64'(d3_empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
